// File: rtl/obsidian_alu_sequencer.sv
// Command-side driver for the combinational obsidian_alu: accepts a command, drives
// registered ALU inputs, captures the ALU result and returns it on a valid/ready channel.
module obsidian_alu_sequencer #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [4:0]       cmd_shamt,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_control,
    output logic [4:0]       alu_shamt,
    input  logic [31:0]      alu_c,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    output logic             resp_zero,
    output logic             resp_neg,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t     state_r;
    logic       op_legal_s;
    logic [3:0] op_ctrl_s;

    // Returns {legal, alu_control} for a command opcode; codes 9-15 are illegal.
    function automatic logic [4:0] map_op(input logic [3:0] op);
        logic [4:0] res;
        case (op)
            4'd0:    res = {1'b1, 4'b0000};
            4'd1:    res = {1'b1, 4'b0001};
            4'd2:    res = {1'b1, 4'b0010};
            4'd3:    res = {1'b1, 4'b0011};
            4'd4:    res = {1'b1, 4'b0100};
            4'd5:    res = {1'b1, 4'b0101};
            4'd6:    res = {1'b1, 4'b0110};
            4'd7:    res = {1'b1, 4'b0111};
            4'd8:    res = {1'b1, 4'b1000};
            default: res = {1'b0, 4'b0000};
        endcase
        return res;
    endfunction

    assign {op_legal_s, op_ctrl_s} = map_op(cmd_op);

    // Ready depends on state alone so a sender can never combinationally loop through it.
    assign cmd_ready = (state_r == ST_IDLE);

    // Sequencer FSM with all ALU-facing and response outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            alu_a       <= 32'd0;
            alu_b       <= 32'd0;
            alu_control <= 4'd0;
            alu_shamt   <= 5'd0;
            resp_valid  <= 1'b0;
            resp_data   <= 32'd0;
            resp_tag    <= '0;
            resp_err    <= 1'b0;
            resp_zero   <= 1'b0;
            resp_neg    <= 1'b0;
            ops_done    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        resp_tag <= cmd_tag;
                        if (op_legal_s) begin
                            alu_a       <= cmd_a;
                            alu_b       <= cmd_b;
                            alu_shamt   <= cmd_shamt;
                            alu_control <= op_ctrl_s;
                            state_r     <= ST_DRIVE;
                        end else begin
                            // Illegal ops bypass the ALU and leave its inputs untouched.
                            resp_data  <= 32'd0;
                            resp_zero  <= 1'b1;
                            resp_neg   <= 1'b0;
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state_r    <= ST_RESP;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    resp_data  <= alu_c;
                    resp_zero  <= (alu_c == 32'd0);
                    resp_neg   <= alu_c[31];
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state_r    <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_valid && resp_ready) begin
                        resp_valid <= 1'b0;
                        ops_done   <= ops_done + CNT_W'(1);
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
